// File: rtl/memory_read_unit.sv
// Purpose : circular-buffer word store; the storage side writes, the consumer side reads.
// Latency : 1 cycle from an accepted rden edge to dout/dvalid; status flags come from registers.
// Backpressure: rden while empty is ignored. wren while full is dropped and sets sticky overflow,
//               unless rden is also high, in which case read and write both proceed.
// Ports   : clk, arst (async active-high); wren/din write side; rden/dout/dvalid read side;
//           empty/full/count status; overflow sticky dropped-write flag.
module memory_read_unit #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       wren,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rden,
  output logic [WIDTH-1:0]           dout,
  output logic                       dvalid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr_ok;
  logic             rd_ok;

  // Flags decode the count register only, so wren/rden never reach them combinationally.
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A full buffer still takes a write when a read frees the slot on the same edge.
  assign rd_ok = rden & ~empty;
  assign wr_ok = wren & (~full | rden);

  // Storage needs no reset: entries are only read when count says they are valid.
  // When full, wp==rp; the read below samples the old word before this write lands.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      dout     <= '0;
      dvalid   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dvalid <= rd_ok;
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        dout <= mem[rp];
        rp   <= rp + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wren & full & ~rden) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_read_unit.sv
module tb_memory_read_unit;

  logic        clk = 1'b0;
  logic        arst;
  logic        wren;
  logic [34:0] din;
  logic        rden;
  logic [34:0] dout;
  logic        dvalid;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int n_vec = 0;
  int n_bad = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  memory_read_unit #(.WIDTH(35), .DEPTH(4)) dut (
    .clk(clk), .arst(arst), .wren(wren), .din(din), .rden(rden),
    .dout(dout), .dvalid(dvalid), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  // Monitor: every dvalid pulse must match the oldest expected read word.
  always @(negedge clk) begin
    if (!arst && dvalid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_data: dvalid with dout=%h but no read was expected", dout);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %h expected %h", dout, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; returns at posedge+1 with inputs idle again.
  task automatic cyc(input logic w, input logic [34:0] d, input logic r);
    wren = w;
    din  = d;
    rden = r;
    @(posedge clk);
    #1;
    wren = 1'b0;
    rden = 1'b0;
  endtask

  task automatic wr(input logic [34:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic rd(input logic [34:0] e);
    exp_q.push_back(e);
    cyc(1'b0, '0, 1'b1);
  endtask

  initial begin
    arst = 1'b1;
    wren = 1'b0;
    rden = 1'b0;
    din  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_overflow", overflow, 0);
    arst = 1'b0;

    // Three writes, then three reads in order.
    wr(35'h000000001);
    wr(35'h7FFFFFFFF);
    wr(35'h123456789);
    chk("w3_count", count, 3);
    chk("w3_empty", empty, 0);
    chk("w3_full", full, 0);
    rd(35'h000000001);
    rd(35'h7FFFFFFFF);
    rd(35'h123456789);
    chk("r3_count", count, 0);
    chk("r3_empty", empty, 1);
    cyc(1'b0, '0, 1'b0);
    chk("idle_dvalid", dvalid, 0);
    chk("idle_dout_hold", dout, 35'h123456789);

    // Read while empty is ignored.
    cyc(1'b0, '0, 1'b1);
    chk("rd_empty_count", count, 0);
    chk("rd_empty_dvalid", dvalid, 0);
    chk("rd_empty_dout", dout, 35'h123456789);

    // Fill, then a dropped write raises overflow.
    wr(35'h100000001);
    wr(35'h200000002);
    wr(35'h300000003);
    wr(35'h400000004);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    cyc(1'b1, 35'h0AAAAAAAA, 1'b0);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    rd(35'h100000001);
    rd(35'h200000002);
    rd(35'h300000003);
    rd(35'h400000004);
    chk("ovf_drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);

    // Full with simultaneous read and write, then wrap-around drain.
    wr(35'h0000000B1);
    wr(35'h0000000B2);
    wr(35'h0000000B3);
    wr(35'h0000000B4);
    exp_q.push_back(35'h0000000B1);
    cyc(1'b1, 35'h555555555, 1'b1);
    chk("fullrw_count", count, 4);
    chk("fullrw_full", full, 1);
    rd(35'h0000000B2);
    rd(35'h0000000B3);
    rd(35'h0000000B4);
    rd(35'h555555555);
    chk("wrap_empty", empty, 1);

    // Empty with simultaneous read and write: no bypass.
    cyc(1'b1, 35'h000000042, 1'b1);
    chk("emptyrw_dvalid", dvalid, 0);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_dout", dout, 35'h555555555);
    rd(35'h000000042);
    chk("emptyrw_after", count, 0);

    // Asynchronous reset between clock edges.
    wr(35'h000000011);
    wr(35'h000000022);
    chk("pre_arst_count", count, 2);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dout", dout, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_dvalid", dvalid, 0);
    arst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 1'b1);
    chk("post_arst_rd_count", count, 0);
    chk("post_arst_rd_dvalid", dvalid, 0);
    chk("post_arst_rd_dout", dout, 0);
    wr(35'h000000077);
    rd(35'h000000077);
    chk("post_arst_final", count, 0);

    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_pending: %0d expected reads never arrived, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_read_unit.md
MEMORY_READ_UNIT -- requirements
Module: memory_read_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 35, which is the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, which is the number of stored words (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port arst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port wren, input, 1 bit: write request from the storage side.
REQ-006 SHALL have port din, input, WIDTH bits: write data, sampled when wren=1.
REQ-007 SHALL have port rden, input, 1 bit: read request from the consumer side.
REQ-008 SHALL have port dout, output, WIDTH bits: registered read data.
REQ-009 SHALL have port dvalid, output, 1 bit: one-cycle pulse marking a new dout.
REQ-010 SHALL have port empty, output, 1 bit: high when count==0.
REQ-011 SHALL have port full, output, 1 bit: high when count==DEPTH.
REQ-012 SHALL have port count, output, log2(DEPTH)+1 bits: number of words stored.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag for a dropped write.

Function
REQ-014 SHALL store words in a circular buffer of DEPTH entries, with write pointer wp and read pointer rp of log2(DEPTH) bits each; both pointers wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write, on the edge where wren=1 and either full=0 or (rden=1 and full=1), as follows: mem[wp]<=din and wp<=wp+1.
REQ-016 SHALL accept a read, on the edge where rden=1 and empty=0, as follows: dout<=mem[rp], rp<=rp+1, and dvalid=1 in the following cycle.
REQ-017 SHALL give a read a latency of 1 cycle, from the rden edge to dout/dvalid valid.
REQ-018 SHALL drive dvalid=0 in every cycle not following an accepted read, and SHALL hold dout at its last read value.
REQ-019 SHALL update count by +1 on a write only, -1 on a read only, and leave it unchanged on a simultaneous accepted write and read.
REQ-020 SHALL ignore rden when empty=1: no pointer change, dvalid=0, dout unchanged.
REQ-021 SHALL not bypass a write into dout when rden and wren are both 1 with empty=1: the read is ignored, the write is stored, and count becomes 1.
REQ-022 SHALL accept both operations when wren and rden are both 1 with full=1: the oldest word is read and the new word is written into the freed slot, leaving count=DEPTH.
REQ-023 SHALL drop the write when wren=1, full=1 and rden=0, leaving memory, pointers and count unchanged, and SHALL set overflow<=1.
REQ-024 SHALL clear overflow only by arst.
REQ-025 SHALL derive empty, full and count from registered state only, with no combinational path from wren or rden.

Reset
REQ-026 SHALL, while arst=1, immediately force wp=0, rp=0, count=0, dout=0, dvalid=0, overflow=0, empty=1 and full=0, independent of clk.
REQ-027 SHALL NOT require memory array contents to be reset; stale entries SHALL be unobservable because empty=1.
REQ-028 SHALL, when arst is asserted mid-operation, discard all stored words and abort any pending dvalid pulse.
REQ-029 SHALL, after arst deasserts, honour wren/rden from the first rising clk edge.

Verification
REQ-030 SHALL cover: after reset, write 0x000000001, 0x7FFFFFFFF, 0x123456789 on three edges -> count=3, empty=0, full=0.
REQ-031 SHALL cover: from REQ-030, three consecutive reads -> dout=0x000000001, 0x7FFFFFFFF, 0x123456789 one cycle after each rden, dvalid high for 3 cycles, then empty=1 and count=0.
REQ-032 SHALL cover: fill with 4 words, then a wren with din=0x0AAAAAAAA and rden=0 -> count stays 4, overflow=1, and a subsequent drain returns the original 4 words.
REQ-033 SHALL cover: full, then wren=1 and rden=1 with din=0x555555555 -> dout=oldest word, count=4, and the 4th subsequent read returns 0x555555555 (pointer wrap).
REQ-034 SHALL cover: empty, then wren=1 and rden=1 with din=0x000000042 -> dvalid=0, count=1, and the next read returns 0x000000042.
REQ-035 SHALL cover: count=2, then arst pulsed between clock edges -> count=0, empty=1, dout=0 and overflow=0 immediately, and rden is ignored until a write.
